// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
// States, ALU-op selects, opcodes and datapath mux selects.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_JAL,
    ST_JALR,
    ST_BRANCH,
    ST_LUI,
    ST_AUIPC,
    ST_TRAP
  } state_e;

  localparam logic [2:0] ALUOP_ADD    = 3'd0;
  localparam logic [2:0] ALUOP_BRANCH = 3'd1;
  localparam logic [2:0] ALUOP_FUNCT  = 3'd2;
  localparam logic [2:0] ALUOP_JAL    = 3'd3;
  localparam logic [2:0] ALUOP_LUI    = 3'd4;
  localparam logic [2:0] ALUOP_AUIPC  = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] SRC_B_4   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  function automatic logic is_mem_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) ||
           (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/rv_mc_if.sv
// Control-to-datapath bundle of the multi-cycle core.
// master: control FSM side; slave: datapath/memory side.
interface rv_mc_if;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       branch_taken_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       mem_addr_sel_o;
  logic       ir_we_o;
  logic       pc_we_o;
  logic       pc_src_o;
  logic [2:0] alu_op_sel_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic       rf_we_o;
  logic [1:0] wb_sel_o;
  logic       retire_o;
  logic       illegal_o;
  logic       bus_err_o;

  modport master (
    input  opcode_i, mem_ready_i, branch_taken_i,
    output mem_req_o, mem_we_o, mem_addr_sel_o,
    output ir_we_o, pc_we_o, pc_src_o,
    output alu_op_sel_o, alu_src_a_o, alu_src_b_o,
    output rf_we_o, wb_sel_o, retire_o,
    output illegal_o, bus_err_o
  );

  modport slave (
    output opcode_i, mem_ready_i, branch_taken_i,
    input  mem_req_o, mem_we_o, mem_addr_sel_o,
    input  ir_we_o, pc_we_o, pc_src_o,
    input  alu_op_sel_o, alu_src_a_o, alu_src_b_o,
    input  rf_we_o, wb_sel_o, retire_o,
    input  illegal_o, bus_err_o
  );
endinterface

// File: rtl/rv_mc_opcode_decode.sv
// Maps the IR opcode to the first execute state of the instruction.
// Unknown opcodes report legal=0 and point at TRAP.
module rv_mc_opcode_decode
  import rv_mc_pkg::*;
(
  input  logic [6:0] opcode,
  output state_e     next_state,
  output logic       legal
);

  always_comb begin
    next_state = ST_TRAP;
    legal      = 1'b1;
    unique case (1'b1)
      (opcode == OP_LOAD),
      (opcode == OP_STORE):  next_state = ST_MEMADR;
      (opcode == OP_REG):    next_state = ST_EXEC_R;
      (opcode == OP_IMM):    next_state = ST_EXEC_I;
      (opcode == OP_JAL):    next_state = ST_JAL;
      (opcode == OP_JALR):   next_state = ST_JALR;
      (opcode == OP_BRANCH): next_state = ST_BRANCH;
      (opcode == OP_LUI):    next_state = ST_LUI;
      (opcode == OP_AUIPC):  next_state = ST_AUIPC;
      default:               legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_mc_control.sv
// Main control FSM of the multi-cycle RV32I core.
// Steps FETCH, DECODE and up to three execute states per instruction.
module rv_mc_control
  import rv_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT     = 0,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input logic   clk_i,
  input logic   rst_ni,
  rv_mc_if.master bus
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  state_e        dec_state;
  logic          dec_legal;
  logic [CW-1:0] cnt_q;
  logic          illegal_q, bus_err_q;
  logic          set_ill, set_berr, tmo;

  logic       mem_req, mem_we, addr_sel;
  logic       ir_we, pc_we, pc_src;
  logic [2:0] alu_op;
  logic [1:0] src_a, src_b, wb_sel;
  logic       rf_we, retire;

  rv_mc_opcode_decode u_dec (
    .opcode     (bus.opcode_i),
    .next_state (dec_state),
    .legal      (dec_legal)
  );

  // Watchdog fires only on a cycle without ready.
  assign tmo = (MEM_TIMEOUT != 0) && (cnt_q == TMAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | set_ill;
      bus_err_q <= bus_err_q | set_berr;
      if (is_mem_state(state_q) && !bus.mem_ready_i)
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    alu_op   = ALUOP_ADD;
    src_a    = SRC_A_RS1;
    src_b    = SRC_B_RS2;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    retire   = 1'b0;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        src_a   = SRC_A_PC;
        src_b   = SRC_B_4;
        if (bus.mem_ready_i) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo) begin
          set_berr = 1'b1;
          state_d  = ST_TRAP;
        end
      end
      ST_DECODE: begin
        src_a   = SRC_A_OLDPC;
        src_b   = SRC_B_IMM;
        state_d = dec_state;
        if (!dec_legal) begin
          set_ill = 1'b1;
          if (!TRAP_ON_ILLEGAL) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end
      end
      ST_MEMADR: begin
        src_b   = SRC_B_IMM;
        state_d = (bus.opcode_i == OP_STORE) ?
                  ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready_i) begin
          state_d = ST_MEMWB;
        end else if (tmo) begin
          set_berr = 1'b1;
          state_d  = ST_TRAP;
        end
      end
      ST_MEMWB: begin
        rf_we   = 1'b1;
        wb_sel  = WB_MEM;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready_i) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (tmo) begin
          set_berr = 1'b1;
          state_d  = ST_TRAP;
        end
      end
      ST_EXEC_R, ST_EXEC_I: begin
        alu_op  = ALUOP_FUNCT;
        src_b   = (state_q == ST_EXEC_I) ?
                  SRC_B_IMM : SRC_B_RS2;
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JAL: begin
        alu_op  = ALUOP_JAL;
        rf_we   = 1'b1;
        wb_sel  = WB_PC;
        pc_we   = 1'b1;
        pc_src  = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JALR: begin
        src_b   = SRC_B_IMM;
        rf_we   = 1'b1;
        wb_sel  = WB_PC;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op  = ALUOP_BRANCH;
        pc_src  = 1'b1;
        pc_we   = bus.branch_taken_i;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_LUI: begin
        alu_op  = ALUOP_LUI;
        src_b   = SRC_B_IMM;
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_AUIPC: begin
        alu_op  = ALUOP_AUIPC;
        src_a   = SRC_A_OLDPC;
        src_b   = SRC_B_IMM;
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_addr_sel_o = addr_sel;
  assign bus.ir_we_o        = ir_we;
  assign bus.pc_we_o        = pc_we;
  assign bus.pc_src_o       = pc_src;
  assign bus.alu_op_sel_o   = alu_op;
  assign bus.alu_src_a_o    = src_a;
  assign bus.alu_src_b_o    = src_b;
  assign bus.rf_we_o        = rf_we;
  assign bus.wb_sel_o       = wb_sel;
  assign bus.retire_o       = retire;
  assign bus.illegal_o      = illegal_q;
  assign bus.bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_rv_mc_control.sv
// Bench for rv_mc_control: random instruction streams against an
// instruction-level model, two parameter sets.
module tb_rv_mc_control;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       asel;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic       rf;
    logic [1:0] wb;
    logic       ret;
  } ctl_t;

  typedef enum {
    K_LOAD, K_STORE, K_R, K_I, K_JAL, K_JALR,
    K_BR, K_LUI, K_AUIPC, K_ILL
  } kind_e;

  logic clk = 1'b0;
  logic rst_na = 1'b0;
  logic rst_nb = 1'b0;
  logic sel = 1'b0;
  logic [6:0] opcode = '0;
  logic ready = 1'b0;
  logic taken = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_ill = 0;
  bit m_berr = 0;
  int m_tmo = 4;
  bit m_trap = 1;

  always #5 clk = ~clk;

  rv_mc_if ifa ();
  rv_mc_if ifb ();

  assign ifa.opcode_i       = opcode;
  assign ifa.mem_ready_i    = ready;
  assign ifa.branch_taken_i = taken;
  assign ifb.opcode_i       = opcode;
  assign ifb.mem_ready_i    = ready;
  assign ifb.branch_taken_i = taken;

  rv_mc_control #(
    .MEM_TIMEOUT     (4),
    .TRAP_ON_ILLEGAL (1'b1)
  ) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_na),
    .bus    (ifa.master)
  );

  rv_mc_control #(
    .MEM_TIMEOUT     (0),
    .TRAP_ON_ILLEGAL (1'b0)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_nb),
    .bus    (ifb.master)
  );

  ctl_t obs_a, obs_b, obs;
  logic [1:0] flg;

  assign obs_a = {ifa.mem_req_o, ifa.mem_we_o,
                  ifa.mem_addr_sel_o, ifa.ir_we_o,
                  ifa.pc_we_o, ifa.pc_src_o,
                  ifa.alu_op_sel_o, ifa.alu_src_a_o,
                  ifa.alu_src_b_o, ifa.rf_we_o,
                  ifa.wb_sel_o, ifa.retire_o};
  assign obs_b = {ifb.mem_req_o, ifb.mem_we_o,
                  ifb.mem_addr_sel_o, ifb.ir_we_o,
                  ifb.pc_we_o, ifb.pc_src_o,
                  ifb.alu_op_sel_o, ifb.alu_src_a_o,
                  ifb.alu_src_b_o, ifb.rf_we_o,
                  ifb.wb_sel_o, ifb.retire_o};
  assign obs = sel ? obs_b : obs_a;
  assign flg = sel ? {ifb.illegal_o, ifb.bus_err_o}
                   : {ifa.illegal_o, ifa.bus_err_o};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic kind_e kind_of(logic [6:0] o);
    case (o)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1100011: return K_BR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  // One clock: compare at negedge, return at posedge+1.
  task automatic step(input string tag, input ctl_t e);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    check({tag, "_flags"}, 32'(flg),
          32'({m_ill, m_berr}));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    ready = 1'($urandom);
    taken = 1'($urandom);
  endtask

  // Request held until ready on cycle w, or watchdog expiry.
  task automatic mem_phase(input string tag, input ctl_t base,
                           input ctl_t on_rdy, input int w,
                           output bit tmo);
    ctl_t e;
    tmo = 0;
    for (int i = 0; i <= w; i++) begin
      ready = (i == w);
      taken = 1'($urandom);
      e = ready ? ctl_t'(base | on_rdy) : base;
      step(tag, e);
      if (ready) break;
      if (m_tmo != 0 && i == m_tmo) begin
        tmo = 1;
        m_berr = 1;
        break;
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] opc,
                           input int fw, input int mw,
                           input logic tk,
                           output int ncyc, output bit trapped);
    ctl_t e, r;
    bit tmo;
    int c0;
    kind_e k;
    c0 = cyc;
    k = kind_of(opc);
    trapped = 0;
    opcode = opc;
    e = '0; e.req = 1; e.a = 2'd1; e.b = 2'd2;
    r = '0; r.irw = 1; r.pcw = 1;
    mem_phase("fetch", e, r, fw, tmo);
    if (tmo) begin
      trapped = 1;
    end else begin
      noise();
      e = '0; e.a = 2'd2; e.b = 2'd1;
      if (k == K_ILL && !m_trap) e.ret = 1;
      step("decode", e);
      if (k == K_ILL) begin
        m_ill = 1;
        trapped = m_trap;
      end
      noise();
      e = '0;
      case (k)
        K_R: begin
          e.op = 3'd2; e.rf = 1; e.ret = 1;
          step("exec_r", e);
        end
        K_I: begin
          e.op = 3'd2; e.b = 2'd1; e.rf = 1; e.ret = 1;
          step("exec_i", e);
        end
        K_JAL: begin
          e.op = 3'd3; e.rf = 1; e.wb = 2'd2;
          e.pcw = 1; e.pcs = 1; e.ret = 1;
          step("jal", e);
        end
        K_JALR: begin
          e.b = 2'd1; e.rf = 1; e.wb = 2'd2;
          e.pcw = 1; e.ret = 1;
          step("jalr", e);
        end
        K_BR: begin
          taken = tk;
          e.op = 3'd1; e.pcs = 1; e.pcw = tk; e.ret = 1;
          step("branch", e);
        end
        K_LUI: begin
          e.b = 2'd1; e.op = 3'd4; e.rf = 1; e.ret = 1;
          step("lui", e);
        end
        K_AUIPC: begin
          e.a = 2'd2; e.b = 2'd1; e.op = 3'd5;
          e.rf = 1; e.ret = 1;
          step("auipc", e);
        end
        K_LOAD, K_STORE: begin
          e.b = 2'd1;
          step("memadr", e);
          e = '0; e.req = 1; e.asel = 1;
          r = '0;
          if (k == K_STORE) begin
            e.we = 1;
            r.ret = 1;
          end
          mem_phase(k == K_STORE ? "memwr" : "memrd",
                    e, r, mw, tmo);
          if (tmo) begin
            trapped = 1;
          end else if (k == K_LOAD) begin
            noise();
            e = '0; e.rf = 1; e.wb = 2'd1; e.ret = 1;
            step("memwb", e);
          end
        end
        default: ;
      endcase
    end
    ncyc = cyc - c0;
  endtask

  task automatic trap_check(input int n);
    repeat (n) begin
      noise();
      opcode = 7'($urandom);
      step("trap", '0);
    end
  endtask

  task automatic do_reset(input bit which);
    sel = which;
    m_tmo = which ? 0 : 4;
    m_trap = !which;
    if (which) rst_nb = 1'b0;
    else rst_na = 1'b0;
    #1;
    check("rst_async_req", 32'(obs.req), 32'(0));
    m_ill = 0;
    m_berr = 0;
    @(posedge clk);
    #1;
    noise();
    step("in_rst", '0);
    step("in_rst", '0);
    if (which) rst_nb = 1'b1;
    else rst_na = 1'b1;
    step("rel", '0);
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [9];
    logic [6:0] bad [4];
    int r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011,
            7'b0010011, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0110111, 7'b0010111};
    bad = '{7'h7F, 7'h00, 7'h0F, 7'h73};
    r = $urandom_range(0, 11);
    if (r < 9) return ops[r];
    return bad[$urandom_range(0, 3)];
  endfunction

  function automatic int pick_wait(int hi);
    if ($urandom_range(0, 2) == 0)
      return $urandom_range(0, hi);
    return 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bit t;
    repeat (2) @(posedge clk);
    #1;
    do_reset(0);

    run_instr(7'b0110011, 0, 0, 0, n, t);
    check("lat_r", n, 3);
    run_instr(7'b0100011, 0, 0, 0, n, t);
    check("lat_store", n, 4);
    run_instr(7'b0000011, 0, 0, 0, n, t);
    check("lat_load", n, 5);
    run_instr(7'b0000011, 0, 3, 0, n, t);
    check("lat_load_w3", n, 8);
    run_instr(7'b1100011, 0, 0, 0, n, t);
    check("lat_br_nt", n, 3);
    run_instr(7'b1100011, 0, 0, 1, n, t);
    check("lat_br_t", n, 3);
    run_instr(7'b1101111, 0, 0, 0, n, t);
    check("lat_jal", n, 3);
    run_instr(7'b0110011, 4, 0, 0, n, t);
    check("ready_on_tmo_cycle", 32'(t), 32'(0));
    check("lat_r_w4", n, 7);
    run_instr(7'b0110011, 3, 0, 0, n, t);
    check("lat_r_w3", n, 6);

    for (int i = 0; i < 150; i++) begin
      run_instr(pick_op(), pick_wait(6), pick_wait(6),
                1'($urandom), n, t);
      if (t) begin
        trap_check(3);
        do_reset(0);
      end
    end

    run_instr(7'b0110011, 1000, 0, 0, n, t);
    check("fetch_timeout", 32'(t), 32'(1));
    trap_check(4);
    do_reset(0);

    run_instr(7'b0000011, 0, 1000, 0, n, t);
    check("memrd_timeout", 32'(t), 32'(1));
    trap_check(2);
    do_reset(0);

    run_instr(7'h7F, 0, 0, 0, n, t);
    check("illegal_trap", 32'(t), 32'(1));
    trap_check(5);
    do_reset(0);

    ready = 1'b0;
    step("fetch_wait",
         '{req: 1'b1, a: 2'd1, b: 2'd2, default: '0});
    do_reset(0);
    run_instr(7'b0010111, 0, 0, 0, n, t);
    check("lat_auipc", n, 3);

    rst_na = 1'b0;
    do_reset(1);
    run_instr(7'h7F, 0, 0, 0, n, t);
    check("illegal_nop_lat", n, 2);
    run_instr(7'b0110111, 0, 0, 0, n, t);
    check("lat_lui_b", n, 3);
    for (int i = 0; i < 120; i++) begin
      run_instr(pick_op(), pick_wait(6), pick_wait(6),
                1'($urandom), n, t);
    end
    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
